uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single `uart_tx` byte transmitter among four byte-producing requesters. It sits between the requester logic and `uart_tx`'s `din`/`din_vld` inputs. `uart_tx` has no ready/busy output, so the arbiter paces itself with a frame-length counter. It guarantees that no new byte is presented to the transmitter before the previous frame has finished on the line.

---
 rtl/uart_tx_arbiter_if.sv | 10 +
 rtl/uart_tx_arbiter.sv | 68 ++++++
 tb/tb_uart_tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side handshake and uart_tx byte feed of the arbiter.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_vld;
  logic [7:0]  tx_data;
  modport master (output req, req_data, input ack, tx_vld, tx_data);
  modport slave  (input req, req_data, output ack, tx_vld, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among four requesters,
// paced by a frame-length counter since uart_tx exposes no busy signal.
module uart_tx_arbiter #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FRAME_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus,
  output logic [1:0]          grant_id,
  output logic                busy
);
  localparam int BAUD_DIV     = CLK_FREQ / BAUD;
  localparam int FRAME_CYCLES = BAUD_DIV * FRAME_BITS;
  localparam int CW           = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    last, sel, idx;
  logic          found, issue;
  // first requester after the last grant wins; the last grantee comes last
  always_comb begin
    sel = last;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && bus.req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    issue   = (state == IDLE || cnt == '0) && |bus.req;
    state_d = (issue || (state == WAIT && cnt != '0)) ? WAIT : IDLE;
    cnt_d   = issue ? CNT_LOAD : (cnt != '0) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_vld  <= 1'b0;
      bus.tx_data <= '0;
      bus.ack     <= '0;
      grant_id    <= '0;
      last        <= 2'd3;
    end else begin
      bus.tx_vld <= issue;
      bus.ack    <= issue ? 4'b0001 << sel : 4'b0000;
      if (issue) begin
        bus.tx_data <= bus.req_data[8*sel +: 8];
        grant_id    <= sel;
        last        <= sel;
      end
    end
  end
  assign busy = (state == WAIT);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, pacing and reset of uart_tx_arbiter.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       busy;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  uart_tx_arbiter_if bus();
  uart_tx_arbiter #(.CLK_FREQ(1000), .BAUD(100), .FRAME_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_vld(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_vld) begin
        at = cyc;
        return;
      end
    end
    check("vld_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 0, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, t0, t1, c, n, prev;
    logic seen;
    int grants [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_vld", bus.tx_vld, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      seen |= bus.tx_vld | busy | (|bus.ack);
    end
    check("idle_quiet", seen, 0);
    // single request: latency, payload, busy window length
    bus.req_data = 32'h0000_0055;
    bus.req = 4'b0001;
    c = cyc;
    wait_vld(5, t);
    check("single_lat", t - c, 1);
    check("single_data", bus.tx_data, 8'h55);
    check("single_ack", bus.ack, 4'b0001);
    check("single_gid", grant_id, 0);
    bus.req = '0;
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("busy_len", n, 100);
    // fresh reset so rotation starts at requester 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_data = 32'h4332_2110;
    bus.req = 4'hF;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      wait_vld(150, t);
      check("rr_gid", grant_id, grants[i]);
      check("rr_data", bus.tx_data, 8'h10 + 8'h11 * grants[i]);
      check("rr_ack", bus.ack, 4'b0001 << grants[i]);
      if (i > 0) check("rr_gap", t - prev, 100);
      prev = t;
      if (i == 6) bus.req = 4'b1011;
      if (i == 0) begin
        @(negedge clk);
        check("vld_pulse", {bus.tx_vld, bus.ack}, 0);
        check("data_hold", bus.tx_data, 8'h10);
      end
    end
    bus.req = '0;
    wait_idle();
    // late request inside a window must wait for the window to close
    bus.req = 4'b0001;
    wait_vld(5, t0);
    bus.req = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.tx_vld;
    end
    bus.req = 4'b0010;
    wait_vld(150, t1);
    check("late_quiet", seen, 0);
    check("late_gap", t1 - t0, 100);
    check("late_gid", grant_id, 1);
    check("late_data", bus.tx_data, 8'h21);
    bus.req = '0;
    wait_idle();
    // reset mid-window aborts pacing at once
    bus.req = 4'b0001;
    wait_vld(5, t);
    bus.req = '0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_vld", bus.tx_vld, 0);
    check("abort_data", bus.tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.req = 4'b0100;
    c = cyc;
    wait_vld(5, t);
    check("post_lat", t - c, 1);
    check("post_gid", grant_id, 2);
    check("post_data", bus.tx_data, 8'h32);
    check("post_ack", bus.ack, 4'b0100);
    check("post_busy", busy, 1);
    bus.req = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
